// File: rtl/make_reset_seq.sv
// Staggered multi-channel reset generator: all channels are held for HOLD_CYCLES, then released one by one, channel 0 first.
// Define MAKE_RESET_SEQ_MASK_EN to add SOFT_MASK, which selects the channels that a soft assert leaves untouched.
module make_reset_seq #(
   parameter int NUM_RST        = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 4,
   parameter int init           = 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ASSERT_IN,
`ifdef MAKE_RESET_SEQ_MASK_EN
   input  logic [NUM_RST-1:0] SOFT_MASK,
`endif
   output logic               ASSERT_OUT,
   output logic [NUM_RST-1:0] OUT_RST
);

   localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = $clog2(NUM_RST) + 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] HOLD    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STAG_LAST = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_RST - 1);
   localparam logic [NUM_RST-1:0] ALL_ON    = '1;
   localparam logic [NUM_RST-1:0] BIT0      = NUM_RST'(1);
   // With no stagger, or only one channel, the hold expiry releases everything at once.
   localparam bit DIRECT_IDLE = (STAGGER_CYCLES == 0) || (NUM_RST == 1);

   logic [1:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic [NUM_RST-1:0] soft_set;
   logic [NUM_RST-1:0] rel_bit;
   logic [NUM_RST-1:0] rel_next;
   logic               rel_done;

`ifdef MAKE_RESET_SEQ_MASK_EN
   // Masked channels keep their value; release always takes the lowest channel still high, so already-low channels cost no slot.
   assign soft_set = OUT_RST | ~SOFT_MASK;
   assign rel_bit  = OUT_RST & (~OUT_RST + BIT0);
   assign rel_next = OUT_RST & ~rel_bit;
   assign rel_done = (rel_next == '0);
`else
   assign soft_set = ALL_ON;
   assign rel_bit  = BIT0 << idx;
   assign rel_next = OUT_RST & ~rel_bit;
   assign rel_done = (idx == IDX_LAST);
`endif

   assign ASSERT_OUT = |OUT_RST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
         idx <= '0;
         if (init != 0) begin
            state   <= HOLD;
            OUT_RST <= ALL_ON;
         end else begin
            state   <= IDLE;
            OUT_RST <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (ASSERT_IN) begin
                  OUT_RST <= soft_set;
                  cnt     <= '0;
                  idx     <= '0;
                  state   <= HOLD;
               end else begin
                  OUT_RST <= '0;
               end
            end
            HOLD: begin
               if (ASSERT_IN) begin
                  cnt <= '0;
               end else if (cnt == HOLD_LAST) begin
                  cnt <= '0;
                  idx <= idx + IDX_W'(1);
                  if (DIRECT_IDLE || rel_done) begin
                     OUT_RST <= '0;
                     state   <= IDLE;
                  end else begin
                     OUT_RST <= rel_next;
                     state   <= RELEASE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RELEASE: begin
               if (ASSERT_IN) begin
                  OUT_RST <= soft_set;
                  cnt     <= '0;
                  idx     <= '0;
                  state   <= HOLD;
               end else if (cnt == STAG_LAST) begin
                  OUT_RST <= rel_next;
                  cnt     <= '0;
                  idx     <= idx + IDX_W'(1);
                  if (rel_done) begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               OUT_RST <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_make_reset_seq.sv
// Bench for make_reset_seq: three instances (staggered init=1, zero-stagger, init=0) checked against a release-time scoreboard.
module tb_make_reset_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, asrt_a = 1'b0, ao_a;
   logic [3:0] out_a;
   logic       rst_b = 1'b1, asrt_b = 1'b0, ao_b;
   logic [2:0] out_b;
   logic       rst_c = 1'b1, asrt_c = 1'b0, ao_c;
   logic [3:0] out_c;
`ifdef MAKE_RESET_SEQ_MASK_EN
   logic [3:0] mask_a = 4'b0000;
   logic [2:0] mask_b = 3'b000;
   logic [3:0] mask_c = 4'b0101;
`endif

   int tests = 0;
   int fails = 0;

   logic [3:0] exp_a[$];
   logic [2:0] exp_b[$];
   logic [3:0] exp_c[$];

   make_reset_seq #(.NUM_RST(4), .HOLD_CYCLES(8), .STAGGER_CYCLES(2), .init(1)) dut_a (
      .CLK(clk), .RST(rst_a), .ASSERT_IN(asrt_a),
`ifdef MAKE_RESET_SEQ_MASK_EN
      .SOFT_MASK(mask_a),
`endif
      .ASSERT_OUT(ao_a), .OUT_RST(out_a));

   make_reset_seq #(.NUM_RST(3), .HOLD_CYCLES(8), .STAGGER_CYCLES(0), .init(1)) dut_b (
      .CLK(clk), .RST(rst_b), .ASSERT_IN(asrt_b),
`ifdef MAKE_RESET_SEQ_MASK_EN
      .SOFT_MASK(mask_b),
`endif
      .ASSERT_OUT(ao_b), .OUT_RST(out_b));

   make_reset_seq #(.NUM_RST(4), .HOLD_CYCLES(8), .STAGGER_CYCLES(2), .init(0)) dut_c (
      .CLK(clk), .RST(rst_c), .ASSERT_IN(asrt_c),
`ifdef MAKE_RESET_SEQ_MASK_EN
      .SOFT_MASK(mask_c),
`endif
      .ASSERT_OUT(ao_c), .OUT_RST(out_c));

   // Expected outputs n edges after the last assert edge: the j-th asserted channel (in index order) falls at hold + j*stag.
   function automatic logic [3:0] model(int n, int hold, int stag, int nrst, logic [3:0] active);
      logic [3:0] v;
      int rank;
      v = 4'b0000;
      rank = 0;
      for (int k = 0; k < nrst; k++) begin
         if (active[k]) begin
            if (n < hold + rank * stag) v[k] = 1'b1;
            rank++;
         end
      end
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests++;
         if (out_a !== 4'b1111 || ao_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_a out=%b ao=%b expected out=1111 ao=1", out_a, ao_a);
         end
         tests++;
         if (out_b !== 3'b111 || ao_b !== 1'b1) begin
            fails++;
            $display("FAIL reset_b out=%b ao=%b expected out=111 ao=1", out_b, ao_b);
         end
         tests++;
         if (out_c !== 4'b0000 || ao_c !== 1'b0) begin
            fails++;
            $display("FAIL reset_c_init0 out=%b ao=%b expected out=0000 ao=0", out_c, ao_c);
         end
      end
   endtask

   task automatic test_power_on_release();
      logic [3:0] e;
      int cyc;
      rst_a = 1'b0;
      for (int n = 1; n <= 16; n++) exp_a.push_back(model(n, 8, 2, 4, 4'b1111));
      cyc = 1;
      while (exp_a.size() != 0) begin
         step();
         e = exp_a.pop_front();
         tests++;
         if (out_a !== e || ao_a !== (e != 4'b0000)) begin
            fails++;
            $display("FAIL power_on_release edge=%0d out=%b ao=%b expected out=%b ao=%b", cyc, out_a, ao_a, e, (e != 4'b0000));
         end
         cyc++;
      end
   endtask

   task automatic test_soft_from_idle();
      logic [3:0] e;
      int cyc;
      for (int i = 0; i < 3; i++) exp_a.push_back(4'b0000);
      for (int n = 0; n <= 16; n++) exp_a.push_back(model(n, 8, 2, 4, 4'b1111));
      cyc = 0;
      while (exp_a.size() != 0) begin
         asrt_a = (cyc == 3);
         step();
         e = exp_a.pop_front();
         tests++;
         if (out_a !== e || ao_a !== (e != 4'b0000)) begin
            fails++;
            $display("FAIL soft_from_idle cyc=%0d out=%b ao=%b expected out=%b ao=%b", cyc, out_a, ao_a, e, (e != 4'b0000));
         end
         cyc++;
      end
      asrt_a = 1'b0;
   endtask

   task automatic test_reassert_release();
      logic [3:0] e;
      int cyc;
      for (int n = 0; n <= 10; n++) exp_a.push_back(model(n, 8, 2, 4, 4'b1111));
      for (int n = 0; n <= 16; n++) exp_a.push_back(model(n, 8, 2, 4, 4'b1111));
      cyc = 0;
      while (exp_a.size() != 0) begin
         asrt_a = (cyc == 0 || cyc == 11);
         step();
         e = exp_a.pop_front();
         tests++;
         if (out_a !== e || ao_a !== (e != 4'b0000)) begin
            fails++;
            $display("FAIL reassert_release cyc=%0d out=%b ao=%b expected out=%b ao=%b", cyc, out_a, ao_a, e, (e != 4'b0000));
         end
         cyc++;
      end
      asrt_a = 1'b0;
   endtask

   task automatic test_hold_extend();
      logic [3:0] e;
      int cyc;
      for (int i = 0; i < 19; i++) exp_a.push_back(4'b1111);
      for (int n = 0; n <= 16; n++) exp_a.push_back(model(n, 8, 2, 4, 4'b1111));
      cyc = 0;
      while (exp_a.size() != 0) begin
         asrt_a = (cyc < 20);
         step();
         e = exp_a.pop_front();
         tests++;
         if (out_a !== e || ao_a !== (e != 4'b0000)) begin
            fails++;
            $display("FAIL hold_extend cyc=%0d out=%b ao=%b expected out=%b ao=%b", cyc, out_a, ao_a, e, (e != 4'b0000));
         end
         cyc++;
      end
      asrt_a = 1'b0;
   endtask

   task automatic test_stagger_zero();
      logic [3:0] tmp;
      logic [2:0] e;
      int cyc;
      for (int n = 0; n <= 10; n++) begin
         tmp = model(n, 8, 0, 3, 4'b0111);
         exp_b.push_back(tmp[2:0]);
      end
      exp_b.push_back(3'b000);
      for (int n = 0; n <= 10; n++) begin
         tmp = model(n, 8, 0, 3, 4'b0111);
         exp_b.push_back(tmp[2:0]);
      end
      cyc = 0;
      while (exp_b.size() != 0) begin
         rst_b  = (cyc == 0);
         asrt_b = (cyc == 12);
         step();
         e = exp_b.pop_front();
         tests++;
         if (out_b !== e || ao_b !== (e != 3'b000)) begin
            fails++;
            $display("FAIL stagger_zero cyc=%0d out=%b ao=%b expected out=%b ao=%b", cyc, out_b, ao_b, e, (e != 3'b000));
         end
         cyc++;
      end
      asrt_b = 1'b0;
   endtask

   task automatic test_init_zero();
      logic [3:0] e;
      logic [3:0] active;
      int cyc;
`ifdef MAKE_RESET_SEQ_MASK_EN
      active = ~mask_c;
`else
      active = 4'b1111;
`endif
      for (int i = 0; i < 3; i++) exp_c.push_back(4'b0000);
      for (int n = 0; n <= 16; n++) exp_c.push_back(model(n, 8, 2, 4, active));
      for (int n = 0; n <= 9; n++) exp_c.push_back(model(n, 8, 2, 4, active));
      for (int i = 0; i < 3; i++) exp_c.push_back(4'b0000);
      cyc = 0;
      while (exp_c.size() != 0) begin
         rst_c  = (cyc == 0 || cyc == 30);
         asrt_c = (cyc == 3 || cyc == 20 || cyc == 30);
         step();
         e = exp_c.pop_front();
         tests++;
         if (out_c !== e || ao_c !== (e != 4'b0000)) begin
            fails++;
            $display("FAIL init_zero_soft cyc=%0d out=%b ao=%b expected out=%b ao=%b", cyc, out_c, ao_c, e, (e != 4'b0000));
         end
         cyc++;
      end
      rst_c  = 1'b0;
      asrt_c = 1'b0;
   endtask

   initial begin
      test_reset();
      test_power_on_release();
      test_soft_from_idle();
      test_reassert_release();
      test_hold_extend();
      test_stagger_zero();
      test_init_zero();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
